// File: rtl/keypoint_row_scanner.sv
// Row-scan controller: walks row_addr over the frame, strobes the line buffer once per row and serialises flagged columns into per-scale {row, col} keypoint writes.
// Latency: RD_LAT + 2 + max(1, popcount) cycles per row, writes one cycle after selection; no backpressure, the host only sees busy/done.
module keypoint_row_scanner #(
    parameter int ROWS       = 480,
    parameter int COLS       = 640,
    parameter int NUM_SCALES = 2,
    parameter int RD_LAT     = 2,
    parameter int KP_AW      = 11,
    localparam int ROW_W     = $clog2(ROWS),
    localparam int COL_W     = $clog2(COLS),
    localparam int KW        = ROW_W + COL_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic [ROW_W-1:0]                row_addr,
    output logic                            buffer_we,
    input  logic [NUM_SCALES*COLS-1:0]      is_keypoint,
    output logic [NUM_SCALES-1:0]           kp_we,
    output logic [NUM_SCALES*KP_AW-1:0]     kp_addr,
    output logic [NUM_SCALES*KW-1:0]        kp_din,
    output logic [NUM_SCALES*(KP_AW+1)-1:0] kp_count,
    output logic [NUM_SCALES-1:0]           kp_overflow
);
    localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int CW    = KP_AW + 1;
    // Detector output is meaningless on the first and last column.
    localparam logic [COLS-1:0] INNER_MASK = {1'b0, {(COLS-2){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        S_IDLE, S_READY, S_CAPTURE, S_DRAIN, S_ADVANCE, S_FINISH
    } state_t;

    state_t           state;
    logic [LAT_W-1:0] lat_cnt;
    logic [ROW_W-1:0] cap_row;
    logic [COLS-1:0]  pending [NUM_SCALES];
    logic             more_pending;

    function automatic logic [COL_W-1:0] lowest_bit(input logic [COLS-1:0] v);
        lowest_bit = '0;
        for (int i = COLS - 1; i >= 0; i--)
            if (v[i]) lowest_bit = COL_W'(i);
    endfunction

    // True when some scale still has a flag left after this cycle's selection.
    always_comb begin
        more_pending = 1'b0;
        for (int s = 0; s < NUM_SCALES; s++)
            if ((pending[s] & (pending[s] - COLS'(1))) != '0) more_pending = 1'b1;
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FINISH);
    assign buffer_we = (state == S_ADVANCE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            row_addr    <= '0;
            lat_cnt     <= '0;
            cap_row     <= '0;
            kp_we       <= '0;
            kp_addr     <= '0;
            kp_din      <= '0;
            kp_count    <= '0;
            kp_overflow <= '0;
            for (int s = 0; s < NUM_SCALES; s++) pending[s] <= '0;
        end else begin
            kp_we <= '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        row_addr    <= '0;
                        lat_cnt     <= '0;
                        kp_count    <= '0;
                        kp_overflow <= '0;
                        state       <= S_READY;
                    end
                end
                S_READY: begin
                    if (lat_cnt == LAT_W'(RD_LAT - 1)) begin
                        lat_cnt <= '0;
                        state   <= S_CAPTURE;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    for (int s = 0; s < NUM_SCALES; s++)
                        pending[s] <= (row_addr > ROW_W'(1)) ?
                                      (is_keypoint[s*COLS +: COLS] & INNER_MASK) : '0;
                    cap_row <= row_addr - ROW_W'(1);
                    state   <= S_DRAIN;
                end
                S_DRAIN: begin
                    for (int s = 0; s < NUM_SCALES; s++) begin
                        if (pending[s] != '0) begin
                            pending[s] <= pending[s] & (pending[s] - COLS'(1));
                            // The count's MSB set means the SRAM is full for this frame.
                            if (!kp_count[s*CW + KP_AW]) begin
                                kp_we[s]                <= 1'b1;
                                kp_addr[s*KP_AW +: KP_AW] <= kp_count[s*CW +: KP_AW];
                                kp_din[s*KW +: KW]      <= {cap_row, lowest_bit(pending[s])};
                                kp_count[s*CW +: CW]    <= kp_count[s*CW +: CW] + CW'(1);
                            end else begin
                                kp_overflow[s] <= 1'b1;
                            end
                        end
                    end
                    if (!more_pending) state <= S_ADVANCE;
                end
                S_ADVANCE: begin
                    if (row_addr == ROW_W'(ROWS - 1)) begin
                        state <= S_FINISH;
                    end else begin
                        row_addr <= row_addr + ROW_W'(1);
                        state    <= S_READY;
                    end
                end
                S_FINISH: begin
                    row_addr <= '0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keypoint_row_scanner.sv
// Directed bench for keypoint_row_scanner: 8x16 frame, two scales, RD_LAT=2, 8-entry keypoint SRAMs.
module tb_keypoint_row_scanner;
    localparam int ROWS = 8, COLS = 16, NS = 2, RD_LAT = 2, KP_AW = 3, KW = 7;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic        busy, done, buffer_we;
    logic [2:0]  row_addr;
    logic [31:0] is_keypoint;
    logic [1:0]  kp_we, kp_overflow;
    logic [5:0]  kp_addr;
    logic [13:0] kp_din;
    logic [7:0]  kp_count;

    keypoint_row_scanner #(
        .ROWS(ROWS), .COLS(COLS), .NUM_SCALES(NS), .RD_LAT(RD_LAT), .KP_AW(KP_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .row_addr(row_addr), .buffer_we(buffer_we), .is_keypoint(is_keypoint),
        .kp_we(kp_we), .kp_addr(kp_addr), .kp_din(kp_din),
        .kp_count(kp_count), .kp_overflow(kp_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Flag source: a pattern present on every row plus one that appears only on a chosen row.
    logic [31:0] pat_all, pat_row;
    logic [2:0]  pat_row_sel;
    logic        pat_row_en;
    assign is_keypoint = pat_all | ((pat_row_en && row_addr == pat_row_sel) ? pat_row : 32'd0);

    typedef struct { int s; int addr; int din; int cyc; } wr_t;
    wr_t wr_q[$];
    int  be_cyc[$];
    int  done_cyc, start_cyc;
    int  tests = 0, fails = 0;

    always @(negedge clk) begin
        wr_t w;
        if (rst_n) begin
            if (buffer_we) be_cyc.push_back(cyc);
            if (done) done_cyc = cyc;
            for (int s = 0; s < NS; s++) begin
                if (kp_we[s]) begin
                    w.s = s;
                    w.addr = int'(kp_addr[s*KP_AW +: KP_AW]);
                    w.din = int'(kp_din[s*KW +: KW]);
                    w.cyc = cyc;
                    wr_q.push_back(w);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_row_addr"}, row_addr, 0);
        chk({tag, "_buffer_we"}, buffer_we, 0);
        chk({tag, "_kp_we"}, kp_we, 0);
        chk({tag, "_kp_addr"}, kp_addr, 0);
        chk({tag, "_kp_din"}, kp_din, 0);
        chk({tag, "_kp_count"}, kp_count, 0);
        chk({tag, "_kp_overflow"}, kp_overflow, 0);
    endtask

    task automatic launch();
        wr_q.delete();
        be_cyc.delete();
        done_cyc = -1;
        start = 1'b1;
        start_cyc = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cyc < 0 && n < 3000) begin step(); n++; end
        chk({tag, "_done_seen"}, done_cyc >= 0, 1);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0;
        pat_all = '0; pat_row = '0; pat_row_sel = '0; pat_row_en = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Empty frame; latency counted inclusively from the start cycle to the done cycle.
        launch();
        wait_done("t1");
        chk("t1_latency", done_cyc - start_cyc + 1, 42);
        chk("t1_be_pulses", be_cyc.size(), 8);
        for (int i = 1; i < 8; i++) chk("t1_be_spacing", be_cyc[i] - be_cyc[i-1], 5);
        chk("t1_writes", wr_q.size(), 0);
        chk("t1_count", kp_count, 0);
        chk("t1_busy_after", busy, 0);

        // Single keypoint at row_addr 3, column 5, scale 0.
        pat_row_en = 1'b1; pat_row_sel = 3'd3; pat_row = 32'h0000_0020;
        launch();
        wait_done("t2");
        chk("t2_writes", wr_q.size(), 1);
        chk("t2_scale", wr_q[0].s, 0);
        chk("t2_addr", wr_q[0].addr, 0);
        chk("t2_din", wr_q[0].din, 7'h25);
        chk("t2_wr_cycle", wr_q[0].cyc, be_cyc[3]);
        chk("t2_count", kp_count, 8'h01);

        // Border columns every row, and a centre flag while the window is not yet full.
        pat_all = 32'h8001_8001; pat_row_sel = 3'd1; pat_row = 32'h0080_0080;
        launch();
        wait_done("t3");
        chk("t3_writes", wr_q.size(), 0);
        chk("t3_count", kp_count, 0);
        chk("t3_latency", done_cyc - start_cyc + 1, 42);

        // Parallel drain at row_addr 4: scale 0 cols {2,3,9}, scale 1 col {4}.
        pat_all = '0; pat_row_sel = 3'd4; pat_row = 32'h0010_020C;
        launch();
        wait_done("t4");
        chk("t4_writes", wr_q.size(), 4);
        chk("t4_w0", {wr_q[0].s, wr_q[0].addr, wr_q[0].din}, {32'd0, 32'd0, 32'h32});
        chk("t4_w1", {wr_q[1].s, wr_q[1].addr, wr_q[1].din}, {32'd1, 32'd0, 32'h34});
        chk("t4_w2", {wr_q[2].s, wr_q[2].addr, wr_q[2].din}, {32'd0, 32'd1, 32'h33});
        chk("t4_w3", {wr_q[3].s, wr_q[3].addr, wr_q[3].din}, {32'd0, 32'd2, 32'h39});
        chk("t4_first_cycle", wr_q[0].cyc, be_cyc[4] - 2);
        chk("t4_same_cycle", wr_q[1].cyc, wr_q[0].cyc);
        chk("t4_consec1", wr_q[2].cyc, wr_q[0].cyc + 1);
        chk("t4_consec2", wr_q[3].cyc, wr_q[0].cyc + 2);
        chk("t4_row_cycles", be_cyc[4] - be_cyc[3], 7);
        chk("t4_count", kp_count, 8'h13);

        // Overflow on scale 1: 14 flags per row from row_addr 2 on, only 8 slots.
        pat_row_en = 1'b0; pat_all = 32'h7FFE_0000;
        launch();
        wait_done("t5");
        chk("t5_writes", wr_q.size(), 8);
        for (int i = 0; i < 8; i++)
            chk("t5_write", {wr_q[i].s, wr_q[i].addr, wr_q[i].din}, {32'd1, i, 32'h10 + i + 1});
        chk("t5_overflow", kp_overflow, 2'b10);
        chk("t5_count", kp_count, 8'h80);
        pat_all = '0;
        launch();
        chk("t5_restart_count", kp_count, 0);
        chk("t5_restart_overflow", kp_overflow, 0);
        wait_done("t5b");

        // Ignored start while busy, then reset in the middle of row 5's drain.
        pat_row_en = 1'b1; pat_row_sel = 3'd5; pat_row = 32'h0000_1248;
        launch();
        n = 0;
        while (row_addr != 3'd2 && n < 500) begin step(); n++; end
        chk("t6_reach_row2", row_addr, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t6_start_ignored_row", row_addr, 2);
        chk("t6_start_ignored_busy", busy, 1);
        n = 0;
        while (!(kp_we[0] && row_addr == 3'd5) && n < 500) begin step(); n++; end
        chk("t6_in_drain", {kp_we[0], row_addr}, {1'b1, 3'd5});
        chk("t6_drain_addr", kp_addr[2:0], 0);
        rst_n = 1'b0;
        step();
        chk_all_zero("t6_reset");
        rst_n = 1'b1;
        repeat (3) step();
        chk("t6_stays_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/keypoint_row_scanner.md
# keypoint_row_scanner

Parametrised row-scan controller for the SIFT detect stage. It steps a shared row address through the image and DoG SRAMs and pulses the line-buffer write enable once per row. Each row it captures the per-scale keypoint flag vectors from the detect_keypoint instances and serialises every set flag into a per-scale keypoint SRAM as a packed {row, col} word. It generalises the two-scale, fixed 480×640 controller to NUM_SCALES scales, any image size and any read latency, and adds overflow detection and keypoint counts.

## Interface
Parameters:
- ROWS, 480, image rows; row_addr counts 0..ROWS-1
- COLS, 640, image columns; width of each flag vector
- NUM_SCALES, 2, number of independent keypoint channels
- RD_LAT, 2, SRAM/buffer cycles from a row_addr change to valid is_keypoint; must be ≥1
- KP_AW, 11, keypoint SRAM address width; depth is 2^KP_AW
- Derived: ROW_W = $clog2(ROWS), COL_W = $clog2(COLS), KW = ROW_W+COL_W

Ports:
- clk  in  1  clock; the block has one clock
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at the end of a frame
- row_addr  out  ROW_W  shared read address for the img/blur SRAMs
- buffer_we  out  1  line-buffer shift strobe; one pulse per row
- is_keypoint  in  NUM_SCALES*COLS  flag vectors; scale s is at [s*COLS +: COLS], bit c = column c
- kp_we  out  NUM_SCALES  per-scale keypoint SRAM write enable
- kp_addr  out  NUM_SCALES*KP_AW  per-scale write address
- kp_din  out  NUM_SCALES*KW  per-scale word: {row[ROW_W-1:0], col[COL_W-1:0]}, row in the MSBs
- kp_count  out  NUM_SCALES*(KP_AW+1)  keypoints written this frame, per scale
- kp_overflow  out  NUM_SCALES  sticky per scale: a keypoint was dropped this frame

## Operation
- The FSM has six states: IDLE, READY, CAPTURE, DRAIN, ADVANCE, FINISH.
- IDLE
  - On start: row_addr←0, all kp_count←0, all kp_overflow←0, then go to READY.
  - Counts and overflow flags keep their values in IDLE so the host can read them after a frame.
- READY
  - Waits exactly RD_LAT cycles using an internal counter, then goes to CAPTURE.
- CAPTURE (one cycle)
  - If row_addr ≥ 2: pending[s] ← is_keypoint[s] with bits 0 and COLS-1 forced to 0.
  - If row_addr < 2: pending ← 0, because the 3-row window is not yet full.
  - Capture row ← row_addr-1 (the centre row of the window). Then go to DRAIN.
- DRAIN
  - Each cycle, independently per scale s with pending[s] ≠ 0:
    - c = index of the lowest set bit; clear that bit.
    - If kp_count[s] < 2^KP_AW: on the next edge kp_we[s]←1, kp_addr[s]←kp_count[s], kp_din[s]←{row, c}, and kp_count[s] increments.
    - Otherwise drop the keypoint, set kp_overflow[s], and leave the address unchanged.
  - Stay in DRAIN while any pending bit remains. The exit cycle is the one in which all pending vectors become 0.
  - DRAIN always lasts at least one cycle, even with no keypoints.
- ADVANCE (one cycle)
  - buffer_we = 1.
  - If row_addr == ROWS-1, go to FINISH.
  - Otherwise row_addr increments and the FSM goes to READY.
- FINISH (one cycle): done = 1, row_addr←0, then go to IDLE.
- start is ignored outside IDLE.
- An rst_n low in any state aborts the frame; every output takes its reset value on that edge.

## Timing
- Reset values: the state is IDLE, and all outputs are 0, including busy, done, row_addr, buffer_we, kp_we, kp_addr, kp_din, kp_count and kp_overflow.
- kp_we, kp_addr and kp_din are registered. Each keypoint write appears one cycle after the DRAIN cycle that selected it.
- kp_we is held high only for consecutive selections. It is 0 in any cycle without a new write.
- buffer_we and done are combinational decodes of the state, one cycle wide.
- Cycles per row = RD_LAT + 1 (CAPTURE) + max(1, max_s popcount(pending[s])) + 1 (ADVANCE).
- Frame latency from start to done: the sum of the per-row cycles plus 2 (the IDLE→READY edge and FINISH).
- Simultaneous events:
  - Scales drain in parallel.
  - A scale that finishes early idles with kp_we[s] = 0 while the other scales continue.
- Wrap-around: kp_count saturates at 2^KP_AW. kp_addr never exceeds 2^KP_AW-1.

## Test plan
Bench parameters: ROWS=8, COLS=16, NUM_SCALES=2, RD_LAT=2, KP_AW=3.

1. Empty frame: start with is_keypoint=0.
   - 8 buffer_we pulses, each 5 cycles apart.
   - done rises exactly 42 cycles after the start edge (8×5+2).
   - kp_we never rises, and counts stay 0.
2. Single keypoint: scale 0 bit 5 is set only while row_addr=3.
   - Exactly one write: kp_we[0]=1, kp_addr=0, kp_din={3'd2, 4'd5}.
   - Final kp_count[0]=1.
3. Border masking: bits 0 and 15 are set on every row, plus bit 7 while row_addr=1.
   - No writes occur on either scale.
4. Parallel drain: while row_addr=4, scale 0 has bits {2,3,9} and scale 1 has bit {4}.
   - Scale 0 writes cols 2, 3, 9 on consecutive cycles.
   - Scale 1 writes col 4 in the first of those cycles.
   - That row takes 2+1+3+1=7 cycles.
5. Overflow: scale 1 has 0x7FFE on every row.
   - The first 8 keypoints are written, at addresses 0..7.
   - kp_overflow[1]=1 and kp_count[1]=8.
   - Scale 0 is unaffected.
   - A second start clears the count and the overflow flag.
6. Mid-frame reset and ignored start:
   - rst_n low during a DRAIN of row 5: all outputs read 0 on the next edge.
   - A start pulse while busy=1 does not restart the frame.
